// File: rtl/alucont_seq.sv
// -----------------------------------------------------------------------------
// alucont_seq
//   Registered ALU control unit with a multi-cycle multiply/divide sequencer.
//   Decodes {aluop, funct} into the ALU operation code and the brn flag, takes
//   requests over a valid/ready handshake, and for mult/multu/div/divu walks an
//   external MDU through N step cycles before reporting the result as valid.
//
// Parameters
//   GW           width of gout (>= 3); the 3-bit code is zero-extended
//   MULT_CYCLES  step cycles for mult/multu (>= 1)
//   DIV_CYCLES   step cycles for div/divu   (>= 1)
//
// Ports
//   clk        in   single clock, all state on the rising edge
//   reset      in   synchronous, active-high
//   in_valid   in   request present
//   in_ready   out  unit can accept (IDLE and reset low)
//   aluop      in   [1:0] {aluop1, aluop0} from main control
//   funct      in   [5:0] instruction function field
//   gout       out  [GW-1:0] registered ALU control code
//   brnout     out  registered brn flag
//   mdu_op     out  [1:0] 00 mult, 01 multu, 10 div, 11 divu (registered)
//   mdu_start  out  one-cycle pulse in the first RUN cycle
//   mdu_step   out  high in every RUN (iteration) cycle
//   out_valid  out  one-cycle pulse: single-cycle result or MDU result valid
//   busy       out  state RUN or DONE
// -----------------------------------------------------------------------------
module alucont_seq #(
  parameter int GW          = 3,
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    aluop,
  input  logic [5:0]    funct,
  output logic [GW-1:0] gout,
  output logic          brnout,
  output logic [1:0]    mdu_op,
  output logic          mdu_start,
  output logic          mdu_step,
  output logic          out_valid,
  output logic          busy
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  // The counter is loaded with N-1 so that RUN lasts exactly N cycles
  // (the cycle in which it reads 0 is still a step cycle).
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  // ALU control codes
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gout_q, gout_d;
  logic            brn_q, brn_d;
  logic [1:0]      mdu_op_q, mdu_op_d;
  logic            start_q, start_d;
  logic            sgl_vld_q, sgl_vld_d;

  logic [2:0]      dec_code;
  logic            dec_brn;
  logic            dec_multi;
  logic            accept;

  // ---------------------------------------------------------------------------
  // Decode of the presented request (only consumed on accept)
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_code  = OP_ADD;
    dec_brn   = 1'b0;
    dec_multi = 1'b0;
    case (aluop)
      2'b00: dec_code = OP_ADD;
      2'b01: dec_code = OP_SUB;
      2'b10: begin
        case (funct)
          6'b100000: dec_code = OP_ADD;
          6'b100010: dec_code = OP_SUB;
          6'b100100: dec_code = OP_AND;
          6'b100101: dec_code = OP_OR;
          6'b101010: dec_code = OP_SLT;
          6'b010101: begin
            dec_code = OP_ADD;
            dec_brn  = 1'b1;
          end
          // mult/multu/div/divu: ALU does the partial-sum adds
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            dec_code  = OP_ADD;
            dec_multi = 1'b1;
          end
          default: dec_code = OP_ADD;
        endcase
      end
      // aluop=11 is a plain add, always single-cycle
      default: dec_code = OP_ADD;
    endcase
  end

  // Combinational in reset so nothing is taken in the cycle reset is high.
  assign in_ready = (state_q == IDLE) && !reset;
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gout_d    = gout_q;
    brn_d     = brn_q;
    mdu_op_d  = mdu_op_q;
    start_d   = 1'b0;
    sgl_vld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          gout_d      = '0;
          gout_d[2:0] = dec_code;
          brn_d       = dec_brn;
          if (dec_multi) begin
            state_d  = RUN;
            mdu_op_d = funct[1:0];
            cnt_d    = funct[1] ? DIV_LOAD : MULT_LOAD;
            start_d  = 1'b1;
          end else begin
            sgl_vld_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Counter saturates at 0; reaching it ends the iteration.
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gout_q    <= '0;
      brn_q     <= 1'b0;
      mdu_op_q  <= 2'b00;
      start_q   <= 1'b0;
      sgl_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gout_q    <= gout_d;
      brn_q     <= brn_d;
      mdu_op_q  <= mdu_op_d;
      start_q   <= start_d;
      sgl_vld_q <= sgl_vld_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all driven from flops)
  // ---------------------------------------------------------------------------
  assign gout      = gout_q;
  assign brnout    = brn_q;
  assign mdu_op    = mdu_op_q;
  assign mdu_start = start_q;
  assign mdu_step  = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  // Aborted ops never reach DONE, so they never raise out_valid.
  assign out_valid = sgl_vld_q || (state_q == DONE);

endmodule

// File: tb/tb_alucont_seq.sv
module tb_alucont_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int gout;
    int brn;
    int op;
    int multi;
    int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  // DUT A: GW=3, MULT_CYCLES=4, DIV_CYCLES=1
  logic       a_reset, a_in_valid, a_in_ready;
  logic [1:0] a_aluop, a_mdu_op;
  logic [5:0] a_funct;
  logic [2:0] a_gout;
  logic       a_brnout, a_mdu_start, a_mdu_step, a_out_valid, a_busy;

  // DUT B: GW=5, MULT_CYCLES=32, DIV_CYCLES=32
  logic       b_reset, b_in_valid, b_in_ready;
  logic [1:0] b_aluop, b_mdu_op;
  logic [5:0] b_funct;
  logic [4:0] b_gout;
  logic       b_brnout, b_mdu_start, b_mdu_step, b_out_valid, b_busy;

  alucont_seq #(.GW(3), .MULT_CYCLES(4), .DIV_CYCLES(1)) u_dut_a (
    .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .aluop(a_aluop), .funct(a_funct), .gout(a_gout), .brnout(a_brnout),
    .mdu_op(a_mdu_op), .mdu_start(a_mdu_start), .mdu_step(a_mdu_step),
    .out_valid(a_out_valid), .busy(a_busy)
  );

  alucont_seq #(.GW(5), .MULT_CYCLES(32), .DIV_CYCLES(32)) u_dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .aluop(b_aluop), .funct(b_funct), .gout(b_gout), .brnout(b_brnout),
    .mdu_op(b_mdu_op), .mdu_start(b_mdu_start), .mdu_step(b_mdu_step),
    .out_valid(b_out_valid), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called just after a negedge: present request, record expected result,
  // hold it across one rising edge. lat = step cycles for multi-cycle ops.
  task automatic a_send(input int op, input int fn, input int g, input int b,
                        input int m, input int mo, input int lat);
    a_in_valid = 1'b1;
    a_aluop    = op[1:0];
    a_funct    = fn[5:0];
    qa.push_back('{g, b, mo, m, cyc + 1 + lat});
    @(negedge clk);
  endtask

  task automatic b_send(input int op, input int fn, input int g, input int b,
                        input int m, input int mo, input int lat);
    b_in_valid = 1'b1;
    b_aluop    = op[1:0];
    b_funct    = fn[5:0];
    qb.push_back('{g, b, mo, m, cyc + 1 + lat});
    @(negedge clk);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (a_out_valid === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_spurious_vld", 32'(a_out_valid), 0);
      end else begin
        ea = qa.pop_front();
        chk("a_gout", 32'(a_gout), ea.gout);
        chk("a_brnout", 32'(a_brnout), ea.brn);
        chk("a_vld_cycle", cyc, ea.cyc);
        if (ea.multi != 0) chk("a_mdu_op", 32'(a_mdu_op), ea.op);
      end
    end
  end

  always @(negedge clk) begin
    if (b_out_valid === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_spurious_vld", 32'(b_out_valid), 0);
      end else begin
        eb = qb.pop_front();
        chk("b_gout", 32'(b_gout), eb.gout);
        chk("b_brnout", 32'(b_brnout), eb.brn);
        chk("b_vld_cycle", cyc, eb.cyc);
        if (eb.multi != 0) chk("b_mdu_op", 32'(b_mdu_op), eb.op);
      end
    end
  end

  initial begin
    int steps;
    a_reset = 1'b1; a_in_valid = 1'b0; a_aluop = 2'b00; a_funct = 6'b000000;
    b_reset = 1'b1; b_in_valid = 1'b0; b_aluop = 2'b00; b_funct = 6'b000000;
    @(negedge clk);
    @(negedge clk);

    // ---- reset state (A) ----
    chk("a_rst_ready", 32'(a_in_ready), 0);
    chk("a_rst_gout", 32'(a_gout), 0);
    chk("a_rst_brn", 32'(a_brnout), 0);
    chk("a_rst_op", 32'(a_mdu_op), 0);
    chk("a_rst_start", 32'(a_mdu_start), 0);
    chk("a_rst_step", 32'(a_mdu_step), 0);
    chk("a_rst_vld", 32'(a_out_valid), 0);
    chk("a_rst_busy", 32'(a_busy), 0);
    a_reset = 1'b0;
    #1;
    chk("a_ready_after_rst", 32'(a_in_ready), 1);

    // ---- decode sweep, one accept per cycle ----
    a_send(2, 'b100000, 2, 0, 0, 0, 0);
    a_send(2, 'b100010, 6, 0, 0, 0, 0);
    a_send(2, 'b100100, 0, 0, 0, 0, 0);
    a_send(2, 'b100101, 1, 0, 0, 0, 0);
    a_send(2, 'b101010, 7, 0, 0, 0, 0);
    a_send(2, 'b010101, 2, 1, 0, 0, 0);
    a_send(0, 'b101010, 2, 0, 0, 0, 0);
    a_send(1, 'b101010, 6, 0, 0, 0, 0);
    a_send(3, 'b101010, 2, 0, 0, 0, 0);
    a_send(2, 'b111111, 2, 0, 0, 0, 0);
    chk("a_ready_b2b", 32'(a_in_ready), 1);
    a_in_valid = 1'b0;
    @(negedge clk);

    // ---- multu, MULT_CYCLES=4 ----
    a_send(2, 'b011001, 2, 0, 1, 1, 4);
    a_in_valid = 1'b0;
    steps = 0;
    for (int k = 0; k < 5; k++) begin
      steps += int'(a_mdu_step);
      chk("a_mult_ready_lo", 32'(a_in_ready), 0);
      chk("a_mult_busy", 32'(a_busy), 1);
      chk("a_mult_start", 32'(a_mdu_start), (k == 0) ? 1 : 0);
      if (k == 0) chk("a_mult_op_at_start", 32'(a_mdu_op), 1);
      @(negedge clk);
    end
    chk("a_mult_steps", steps, 4);
    chk("a_mult_ready_end", 32'(a_in_ready), 1);
    chk("a_mult_busy_end", 32'(a_busy), 0);

    // ---- div, DIV_CYCLES=1, request held continuously ----
    a_in_valid = 1'b1; a_aluop = 2'b10; a_funct = 6'b011010;
    qa.push_back('{2, 0, 2, 1, cyc + 2});
    qa.push_back('{2, 0, 2, 1, cyc + 5});
    @(negedge clk);
    chk("a_div1_start", 32'(a_mdu_start), 1);
    chk("a_div1_step", 32'(a_mdu_step), 1);
    @(negedge clk);
    chk("a_div1_done_start", 32'(a_mdu_start), 0);
    chk("a_div1_done_step", 32'(a_mdu_step), 0);
    chk("a_div1_done_ready", 32'(a_in_ready), 0);
    chk("a_div1_done_busy", 32'(a_busy), 1);
    @(negedge clk);
    chk("a_div1_idle_ready", 32'(a_in_ready), 1);
    @(negedge clk);
    chk("a_div2_start", 32'(a_mdu_start), 1);
    a_in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // ---- DUT B: reset state, GW=5 slt ----
    chk("b_rst_ready", 32'(b_in_ready), 0);
    chk("b_rst_gout", 32'(b_gout), 0);
    chk("b_rst_busy", 32'(b_busy), 0);
    b_reset = 1'b0;
    #1;
    b_send(2, 'b101010, 7, 0, 0, 0, 0);
    b_in_valid = 1'b0;
    @(negedge clk);

    // ---- div with DIV_CYCLES=32, aborted by reset at step 10 ----
    b_in_valid = 1'b1; b_aluop = 2'b10; b_funct = 6'b011010;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("b_div_start", 32'(b_mdu_start), 1);
    chk("b_div_op", 32'(b_mdu_op), 2);
    chk("b_div_gout", 32'(b_gout), 2);
    chk("b_div_brn", 32'(b_brnout), 0);
    repeat (9) @(negedge clk);
    chk("b_div_step10", 32'(b_mdu_step), 1);
    chk("b_div_busy10", 32'(b_busy), 1);
    b_reset = 1'b1;
    @(negedge clk);
    chk("b_abort_step", 32'(b_mdu_step), 0);
    chk("b_abort_busy", 32'(b_busy), 0);
    chk("b_abort_vld", 32'(b_out_valid), 0);
    chk("b_abort_start", 32'(b_mdu_start), 0);
    chk("b_abort_gout", 32'(b_gout), 0);
    chk("b_abort_op", 32'(b_mdu_op), 0);
    chk("b_abort_ready_in_rst", 32'(b_in_ready), 0);
    b_reset = 1'b0;
    #1;
    chk("b_ready_after_abort", 32'(b_in_ready), 1);
    b_send(2, 'b100000, 2, 0, 0, 0, 0);
    b_in_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("b_idle_end", 32'(b_busy), 0);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alucont_seq.md
# alucont_seq

Registered, parametrised ALU control unit with a multi-cycle sequencer. It decodes `aluop`/`funct` into the ALU operation code and the `brn` flag, as the single-cycle control does. It adds a valid/ready handshake and iterative multiply/divide sequencing, driving step strobes for an external multiply/divide datapath. It sits between the main control/decode stage and the ALU/MDU in the multi-cycle datapath.

## Interface
- `GW`, 3: width of `gout`; must be ≥3; the 3-bit code is zero-extended into upper bits.
- `MULT_CYCLES`, 32: step cycles for mult/multu; must be ≥1.
- `DIV_CYCLES`, 32: step cycles for div/divu; must be ≥1.

- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept (state IDLE and `reset` low).
- `aluop`  in  2  {aluop1, aluop0} from main control.
- `funct`  in  6  instruction function field f5..f0.
- `gout`  out  GW  registered ALU control code.
- `brnout`  out  1  registered brn flag.
- `mdu_op`  out  2  00 mult, 01 multu, 10 div, 11 divu (registered).
- `mdu_start`  out  1  one-cycle pulse at start of a multi-cycle op.
- `mdu_step`  out  1  high each iteration cycle.
- `out_valid`  out  1  one-cycle pulse: `gout`/`brnout` (single) or MDU result (multi) valid.
- `busy`  out  1  state RUN or DONE.

## Operation
- Accept happens when `in_valid & in_ready`. Requests while `in_ready=0` are ignored, not queued.
- Decode on accept:
  - aluop=00 → 010.
  - aluop=01 → 110.
  - aluop=11 → 010, and the op is treated as single-cycle.
- aluop=10 (R-type), by funct:
  - 100000 add → 010.
  - 100010 sub → 110.
  - 100100 and → 000.
  - 100101 or → 001.
  - 101010 slt → 111.
  - 010101 brn → 010 with `brnout=1`.
  - 011000/011001/011010/011011 → multi-cycle, with `mdu_op` = funct[1:0].
  - Any other funct → 010.
- `brnout=1` only for aluop=10 with funct=010101; 0 for every other accepted op.
- For multi-cycle ops, `gout` is 010 (add, used for partial sums) and `brnout` is 0.
- `gout`, `brnout` and `mdu_op` update only on accept and hold until the next accept.
- FSM:
  - IDLE: single-cycle accept stays in IDLE; multi-cycle accept goes to RUN.
  - RUN: counter loaded with N−1 on entry (N = MULT_CYCLES for funct[1]=0, DIV_CYCLES for funct[1]=1). Decrements each cycle; at 0 go to DONE.
  - DONE: go to IDLE after one cycle.
- Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES))+1; no wrap (it stops at 0).

## Timing
- Reset values in the cycle after `reset` is sampled high:
  - `gout`=0, `brnout`=0, `mdu_op`=0.
  - `mdu_start`=0, `mdu_step`=0, `out_valid`=0, `busy`=0.
  - State IDLE, counter 0.
- `in_ready`=0 while `reset` is high.
- Single-cycle op accepted at edge t:
  - Outputs are valid and `out_valid`=1 during cycle t+1.
  - `in_ready` stays 1, so back-to-back accepts give 1 op/cycle.
- Multi-cycle op accepted at edge t:
  - `mdu_start`=1 in cycle t+1 only.
  - `mdu_step`=1 in cycles t+1..t+N, and `busy`=1 from t+1.
  - DONE in cycle t+N+1: `out_valid`=1, `busy`=1, `mdu_step`=0.
  - IDLE again at t+N+2, with `in_ready`=1.
- N=1: start and the single step occur in the same cycle; DONE follows next.
- `out_valid` is never asserted for an aborted op.
- Reset mid-RUN or mid-DONE: the next cycle is IDLE, with no `out_valid` and no further `mdu_step`; `gout`/`mdu_op` are cleared to 0.
- `in_valid` held high through RUN/DONE: the next accept occurs only in the first IDLE cycle.

## Test plan
- Reset then decode sweep, one accept per cycle: aluop=10 with funct 100000, 100010, 100100, 100101, 101010, 010101 → `gout` 010, 110, 000, 001, 111, 010 in successive cycles; `brnout`=1 only on the last; `out_valid`=1 in each.
- aluop=00 then aluop=01, each with funct=101010 → `gout`=010 then 110, `brnout`=0 in both.
- MULT_CYCLES=4, accept funct=011001 at t:
  - `mdu_start` pulses at t+1 with `mdu_op`=01.
  - `mdu_step` is high for exactly 4 cycles.
  - `out_valid` at t+5; `in_ready`=0 for t+1..t+5.
- DIV_CYCLES=1, accept funct=011010 → `mdu_start` and `mdu_step` both high in t+1 only, `out_valid` at t+2; a second div presented continuously is accepted at t+3.
- Accept div (DIV_CYCLES=32); assert `reset` for one cycle at step 10 → IDLE next cycle, all outputs 0, no `out_valid`; a new add request is accepted immediately after and gives `gout`=010.
- GW=5, accept funct=101010 → `gout`=5'b00111.
